// File: rtl/stuff_frame_ctrl.sv
// HDLC-style bit-stuffing framer: OPEN flag, stuffed payload, optional FCS, CLOSE flag, ABORT on underrun.
// Define STUFF_FCS_EN to append a stuffed CRC-16/X.25 FCS after the payload.
module stuff_frame_ctrl #(
    parameter int          ONES_LIMIT = 5,
    parameter logic [7:0]  FLAG       = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx_valid,
    output logic       tx_bit,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [2:0] LIMIT = 3'(ONES_LIMIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OPEN  = 3'd1,
        DATA  = 3'd2,
`ifdef STUFF_FCS_EN
        FCS   = 3'd3,
`endif
        CLOSE = 3'd4,
        ABORT = 3'd5
    } state_t;

`ifdef STUFF_FCS_EN
    localparam state_t POST_DATA = FCS;
`else
    localparam state_t POST_DATA = CLOSE;
`endif

    state_t      state_reg, state_next;
    logic [7:0]  hold_data_reg, hold_data_next;
    logic        hold_last_reg, hold_last_next;
    logic        hold_full_reg, hold_full_next;
    logic [7:0]  shift_reg, shift_next;
    logic        last_reg, last_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [2:0]  ones_reg, ones_next;
    logic        end_pend_reg, end_pend_next;
    logic        frame_done_reg, frame_done_next;
    logic        underrun_reg, underrun_next;
`ifdef STUFF_FCS_EN
    logic [15:0] crc_reg, crc_next;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = {1'b0, c[15:1]};
        if (c[0] ^ b)
            r = r ^ 16'h8408;
        return r;
    endfunction
`endif

    logic xfer;
    logic stuff;

    assign stuff      = (ones_reg == LIMIT);
    assign tx_valid   = (state_reg != IDLE);
    assign busy       = (state_reg != IDLE);
    assign xfer       = tx_valid && tx_ready;
    assign s_ready    = !hold_full_reg;
    assign frame_done = frame_done_reg;
    assign underrun   = underrun_reg;

    always_comb begin
        tx_bit = 1'b1;
        case (state_reg)
            OPEN, CLOSE: tx_bit = FLAG[cnt_reg[2:0]];
            DATA:        tx_bit = stuff ? 1'b0 : shift_reg[0];
`ifdef STUFF_FCS_EN
            FCS:         tx_bit = stuff ? 1'b0 : ~crc_reg[0];
`endif
            default:     tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        hold_data_next  = hold_data_reg;
        hold_last_next  = hold_last_reg;
        hold_full_next  = hold_full_reg;
        shift_next      = shift_reg;
        last_next       = last_reg;
        cnt_next        = cnt_reg;
        ones_next       = ones_reg;
        end_pend_next   = end_pend_reg;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;
`ifdef STUFF_FCS_EN
        crc_next        = crc_reg;
`endif

        case (state_reg)
            IDLE: begin
                cnt_next      = 4'd0;
                ones_next     = 3'd0;
                end_pend_next = 1'b0;
                if (hold_full_reg)
                    state_next = OPEN;
            end
            OPEN: begin
                ones_next = 3'd0;
`ifdef STUFF_FCS_EN
                crc_next  = 16'hFFFF;
`endif
                if (xfer) begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg[2:0] == 3'd7) begin
                        cnt_next       = 4'd0;
                        shift_next     = hold_data_reg;
                        last_next      = hold_last_reg;
                        hold_full_next = 1'b0;
                        state_next     = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (stuff) begin
                        // Inserted zero: no payload consumed; may be the trailer after the final byte.
                        ones_next = 3'd0;
                        if (end_pend_reg) begin
                            end_pend_next = 1'b0;
                            cnt_next      = 4'd0;
                            state_next    = POST_DATA;
                        end
                    end else begin
                        ones_next  = shift_reg[0] ? ones_reg + 3'd1 : 3'd0;
`ifdef STUFF_FCS_EN
                        crc_next   = crc_step(crc_reg, shift_reg[0]);
`endif
                        shift_next = {1'b0, shift_reg[7:1]};
                        cnt_next   = cnt_reg + 4'd1;
                        if (cnt_reg[2:0] == 3'd7) begin
                            cnt_next = 4'd0;
                            if (last_reg) begin
                                if (ones_next == LIMIT)
                                    end_pend_next = 1'b1;
                                else
                                    state_next = POST_DATA;
                            end else if (hold_full_reg) begin
                                shift_next     = hold_data_reg;
                                last_next      = hold_last_reg;
                                hold_full_next = 1'b0;
                            end else begin
                                underrun_next = 1'b1;
                                ones_next     = 3'd0;
                                state_next    = ABORT;
                            end
                        end
                    end
                end
            end
`ifdef STUFF_FCS_EN
            FCS: begin
                if (xfer) begin
                    if (stuff) begin
                        ones_next = 3'd0;
                        if (end_pend_reg) begin
                            end_pend_next = 1'b0;
                            cnt_next      = 4'd0;
                            state_next    = CLOSE;
                        end
                    end else begin
                        // The CRC register is complemented on the fly and drained LSB-first.
                        ones_next = ~crc_reg[0] ? ones_reg + 3'd1 : 3'd0;
                        crc_next  = {1'b0, crc_reg[15:1]};
                        cnt_next  = cnt_reg + 4'd1;
                        if (cnt_reg == 4'd15) begin
                            cnt_next = 4'd0;
                            if (ones_next == LIMIT)
                                end_pend_next = 1'b1;
                            else
                                state_next = CLOSE;
                        end
                    end
                end
            end
`endif
            CLOSE, ABORT: begin
                ones_next = 3'd0;
                if (xfer) begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg[2:0] == 3'd7) begin
                        cnt_next        = 4'd0;
                        frame_done_next = (state_reg == CLOSE);
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (s_valid && !hold_full_reg) begin
            hold_data_next = s_data;
            hold_last_next = s_last;
            hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            hold_data_reg  <= 8'h00;
            hold_last_reg  <= 1'b0;
            hold_full_reg  <= 1'b0;
            shift_reg      <= 8'h00;
            last_reg       <= 1'b0;
            cnt_reg        <= 4'd0;
            ones_reg       <= 3'd0;
            end_pend_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
`ifdef STUFF_FCS_EN
            crc_reg        <= 16'hFFFF;
`endif
        end else begin
            state_reg      <= state_next;
            hold_data_reg  <= hold_data_next;
            hold_last_reg  <= hold_last_next;
            hold_full_reg  <= hold_full_next;
            shift_reg      <= shift_next;
            last_reg       <= last_next;
            cnt_reg        <= cnt_next;
            ones_reg       <= ones_next;
            end_pend_reg   <= end_pend_next;
            frame_done_reg <= frame_done_next;
            underrun_reg   <= underrun_next;
`ifdef STUFF_FCS_EN
            crc_reg        <= crc_next;
`endif
        end
    end

endmodule

// File: tb/tb_stuff_frame_ctrl.sv
// Directed bench for stuff_frame_ctrl: captures every transferred line bit and compares whole frames.
module tb_stuff_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       tx_valid;
    logic       tx_bit;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    int checks = 0;
    int passes = 0;

    logic         toggle_en = 1'b0;
    int           obs_n;
    logic [127:0] obs_vec;
    int           done_cnt;
    int           under_cnt;
    int           under_at;
    int           cyc = 0;
    int           xfer_cyc [0:127];

    localparam string FL = "01111110";

    stuff_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .tx_valid   (tx_valid),
        .tx_bit     (tx_bit),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = toggle_en ? ~tx_ready : 1'b1;
        end
    end

    // Line monitor: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (underrun === 1'b1) begin
            under_cnt = under_cnt + 1;
            under_at  = obs_n;
        end
        if (frame_done === 1'b1)
            done_cnt = done_cnt + 1;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (obs_n < 128) begin
                obs_vec[obs_n]  = tx_bit;
                xfer_cyc[obs_n] = cyc;
            end
            obs_n = obs_n + 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] to_vec(input string s);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++)
            v[i] = (s[i] == "1");
        return v;
    endfunction

    task automatic clear_mon();
        obs_n     = 0;
        obs_vec   = '0;
        done_cnt  = 0;
        under_cnt = 0;
        under_at  = -1;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] d, input logic l);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check({tag, "_accept_timeout"}, 128'(ok), 128'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        bit seen;
        bit idle;
        seen = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3000 && seen; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle)
            check({tag, "_idle_timeout"}, 128'(idle), 128'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [127:0] bytes, input int n,
                             input bit with_last, input int gap, input string exp,
                             input int exp_done, input int exp_under);
        clear_mon();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send_byte(tag, bytes[8*i +: 8], with_last && (i == n - 1));
        end
        wait_frame(tag);
        check({tag, "_nbits"}, 128'(obs_n), 128'(exp.len()));
        check({tag, "_bits"}, obs_vec, to_vec(exp));
        check({tag, "_frame_done"}, 128'(done_cnt), 128'(exp_done));
        check({tag, "_underrun"}, 128'(under_cnt), 128'(exp_under));
        check({tag, "_busy"}, 128'(busy), 128'd0);
        $display("frame %s: %0d bits, frame_done=%0d underrun=%0d", tag, obs_n, done_cnt, under_cnt);
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 128'(tx_valid), 128'd0);
        check("rst_tx_bit", 128'(tx_bit), 128'd1);
        check("rst_s_ready", 128'(s_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_frame_done", 128'(frame_done), 128'd0);
        check("rst_underrun", 128'(underrun), 128'd0);
        $display("reset: tx_valid=%b tx_bit=%b s_ready=%b busy=%b", tx_valid, tx_bit, s_ready, busy);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

`ifndef STUFF_FCS_EN
        run_frame("byte00", 128'h00, 1, 1'b1, 0, {FL, "00000000", FL}, 1, 0);
        run_frame("byteFF", 128'hFF, 1, 1'b1, 0, {FL, "111110111", FL}, 1, 0);
        run_frame("byteF8_trail", 128'hF8, 1, 1'b1, 0, {FL, "000111110", FL}, 1, 0);
        run_frame("two_bytes", 128'h0201, 2, 1'b1, 1, {FL, "10000000", "01000000", FL}, 1, 0);
        check("two_bytes_no_gap", 128'(xfer_cyc[16] - xfer_cyc[15]), 128'd1);
        toggle_en = 1'b1;
        run_frame("toggle_FF", 128'hFF, 1, 1'b1, 0, {FL, "111110111", FL}, 1, 0);
        toggle_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`else
        run_frame("crc_123456789", 128'h393837363534333231, 9, 1'b1, 0,
                  {FL, "10001100", "01001100", "11001100", "00101100", "10101100",
                   "01101100", "11101100", "00011100", "10011100",
                   "01110110", "00001001", FL}, 1, 0);
        toggle_en = 1'b1;
        run_frame("crc_toggle", 128'h393837363534333231, 9, 1'b1, 0,
                  {FL, "10001100", "01001100", "11001100", "00101100", "10101100",
                   "01101100", "11101100", "00011100", "10011100",
                   "01110110", "00001001", FL}, 1, 0);
        toggle_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        run_frame("abort55", 128'h55, 1, 1'b0, 0, {FL, "10101010", "11111111"}, 0, 1);
        check("abort55_under_pos", 128'(under_at), 128'd16);

        // Reset while DATA bit 3 is on the line.
        clear_mon();
        send_byte("rst_mid", 8'h00, 1'b1);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                #1;
                if (obs_n == 11) begin
                    hit = 1'b1;
                    break;
                end
            end
            if (!hit)
                check("rst_mid_reach_timeout", 128'(hit), 128'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx_valid", 128'(tx_valid), 128'd0);
        check("rst_mid_busy", 128'(busy), 128'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_nbits", 128'(obs_n), 128'd12);
        check("rst_mid_underrun", 128'(under_cnt), 128'd0);
        check("rst_mid_frame_done", 128'(done_cnt), 128'd0);
        check("rst_mid_idle_tx_valid", 128'(tx_valid), 128'd0);
        $display("rst_mid: %0d bits before reset, underrun=%0d frame_done=%0d", obs_n, under_cnt, done_cnt);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stuff_frame_ctrl.md
STUFF_FRAME_CTRL -- requirements
Module: stuff_frame_ctrl

Interface
REQ-001 SHALL have parameter ONES_LIMIT, default 5: number of consecutive payload ones after which a 0 is inserted.
REQ-002 SHALL have parameter FLAG, default 8'h7E: frame delimiter byte.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port s_valid, input, 1: upstream byte valid.
REQ-006 SHALL have port s_data, input, 8: upstream payload byte.
REQ-007 SHALL have port s_last, input, 1: the byte is the final payload byte of the frame.
REQ-008 SHALL have port s_ready, output, 1: the holding register is empty.
REQ-009 SHALL have port tx_valid, output, 1: tx_bit is valid.
REQ-010 SHALL have port tx_bit, output, 1: serial line bit, LSB of each byte first.
REQ-011 SHALL have port tx_ready, input, 1: downstream accepts the bit.
REQ-012 SHALL have port busy, output, 1: the FSM is not in IDLE.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse after the last closing-flag bit transfers.
REQ-014 SHALL have port underrun, output, 1: one-cycle pulse when a frame is aborted.

Function
REQ-015 SHALL accept a byte when s_valid && s_ready; s_ready = !hold_full.
REQ-016 SHALL advance one bit only on a transfer (tx_valid && tx_ready); tx_bit SHALL hold while tx_ready=0.
REQ-017 SHALL implement FSM states IDLE, OPEN, DATA, FCS, CLOSE, ABORT.
REQ-018 IDLE: tx_valid=0, tx_bit=1; on hold_full go to OPEN, with tx_valid high on the next cycle.
REQ-019 OPEN/CLOSE: SHALL send the 8 FLAG bits LSB-first, unstuffed, and clear the ones counter.
REQ-020 OPEN→DATA after bit 7: move the holding register into the shift register, freeing hold.
REQ-021 DATA: SHALL count consecutive transmitted ones; the count reaching ONES_LIMIT SHALL make the next transferred bit an inserted 0 that consumes no payload bit and clears the count; any transmitted 0 clears the count.
REQ-022 DATA, last payload bit transferred with s_last latched: go to FCS (macro defined) or CLOSE (macro not defined).
REQ-023 DATA, last bit transferred, not last, hold_full: load the next byte with no gap cycle.
REQ-024 DATA, last bit transferred, not last, hold empty: pulse underrun and go to ABORT.
REQ-025 ABORT: SHALL send 8 ones unstuffed, then go to IDLE without frame_done.
REQ-026 A pending inserted 0 after the final payload ones SHALL be sent before FCS/CLOSE.
REQ-027 CLOSE→IDLE after bit 7 with a frame_done pulse; the next frame SHALL get its own OPEN flag.
REQ-028 The ones counter SHALL be 3 bits and never exceed ONES_LIMIT.

Reset
REQ-029 On rst, in the cycle after rst is sampled: FSM=IDLE, hold_full=0, counters=0, tx_valid=0, tx_bit=1, s_ready=1, busy=0, frame_done=0, underrun=0.
REQ-030 rst mid-frame SHALL drop the frame silently, with no underrun and no flag.

Configuration
REQ-031 Macro STUFF_FCS_EN defined: SHALL compute CRC-16/X.25 over the unstuffed payload bits and send it in state FCS (16 bits, LSB-first, low byte first, stuffed like payload).
- CRC-16/X.25 parameters: reflected polynomial 0x8408, init 0xFFFF, final XOR 0xFFFF.
- CRC SHALL re-initialise in OPEN.
REQ-032 Macro STUFF_FCS_EN not defined: no FCS state and no CRC logic; DATA SHALL go directly to CLOSE.

Verification
REQ-033 SHALL cover: reset, one byte 0x00 with s_last, tx_ready=1, macro off -> 01111110, 00000000, 01111110 (24 bits), then frame_done.
REQ-034 SHALL cover: byte 0xFF with s_last, macro off -> payload bits 1,1,1,1,1,0,1,1,1 (9 bits) between the flags.
REQ-035 SHALL cover: bytes 0x01 then 0x02, second byte valid one cycle late -> payload bit 7 of 0x01 is followed by 0x02 bit 0 within one bit transfer, underrun=0.
REQ-036 SHALL cover: byte 0x55 without s_last and no further byte -> underrun pulse, then 8 ones, then busy=0 and frame_done=0.
REQ-037 SHALL cover: macro on, payload "123456789" (0x31..0x39) -> FCS 0x906E sent as 0x6E then 0x90 (stuffed), then the closing flag.
REQ-038 SHALL cover: tx_ready toggled 1/0 every cycle -> bit stream identical to the tx_ready=1 case.
REQ-039 SHALL cover: rst asserted at DATA bit 3 -> tx_valid=0 on the next cycle, with no further bits, underrun or frame_done.
